// File: rtl/pendulum_pkg.sv
// Shared definitions for the pendulum plant model.
//   FRAC_BITS   : fractional bits of the Q8.8 state
//   Q_WIDTH     : width of the Q8.8 position/velocity state
//   INT_WIDTH   : width of the published integer outputs
//   ACC_WIDTH   : width of the intermediate acceleration term
//   state_e     : update sequencer states
package pendulum_pkg;

    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned Q_WIDTH   = 16;
    localparam int unsigned INT_WIDTH = Q_WIDTH - FRAC_BITS;
    localparam int unsigned ACC_WIDTH = 18;

    typedef enum logic [2:0] {
        StIdle,
        StAccel,
        StVelocity,
        StPosition,
        StPublish
    } state_e;

endpackage

// File: rtl/saturating_adder.sv
// Signed Q8.8 adder that clamps to the 16-bit range instead of wrapping.
//   a_i, b_i : signed addends
//   sum_o    : clamped sum
//   clamp_o  : high when the true sum was outside [-32768, 32767]
module saturating_adder
    import pendulum_pkg::*;
(
    input  logic signed [Q_WIDTH-1:0] a_i,
    input  logic signed [Q_WIDTH-1:0] b_i,
    output logic signed [Q_WIDTH-1:0] sum_o,
    output logic                      clamp_o
);

    logic [Q_WIDTH:0] wide;

    always_comb begin
        wide    = {a_i[Q_WIDTH-1], a_i} + {b_i[Q_WIDTH-1], b_i};
        // Overflow when the two top bits of the sign-extended sum disagree.
        clamp_o = wide[Q_WIDTH] ^ wide[Q_WIDTH-1];
        if (!clamp_o) begin
            sum_o = wide[Q_WIDTH-1:0];
        end else if (wide[Q_WIDTH]) begin
            sum_o = {1'b1, {(Q_WIDTH-1){1'b0}}};
        end else begin
            sum_o = {1'b0, {(Q_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/pendulum_plant.sv
// Discrete spring/mass plant stepped once every TICK_DIVIDER clocks.
// Optional feature: define PENDULUM_DAMPING_EN to add a velocity damping term.
//   clock       : sole clock, rising edge
//   isReset     : synchronous active-high reset
//   forceIn     : signed control effort (the name "force" is a reserved word)
//   positionOut : integer part of the Q8.8 position
//   velocityOut : integer part of the Q8.8 velocity
//   sampleValid : one-cycle pulse when the outputs carry a new sample
//   saturated   : last update clamped position or velocity
//   overrun     : sticky, a tick arrived while an update was running
module pendulum_plant
    import pendulum_pkg::*;
#(
    parameter int unsigned TICK_DIVIDER  = 1000,
    parameter int          INIT_POSITION = 30,
    parameter int unsigned SPRING_SHIFT  = 3,
    parameter int unsigned DT_SHIFT      = 2,
    parameter int unsigned DAMP_SHIFT    = 4
) (
    input  logic                        clock,
    input  logic                        isReset,
    input  logic signed [INT_WIDTH-1:0] forceIn,
    output logic signed [INT_WIDTH-1:0] positionOut,
    output logic signed [INT_WIDTH-1:0] velocityOut,
    output logic                        sampleValid,
    output logic                        saturated,
    output logic                        overrun
);

    localparam int unsigned CntW = $clog2(TICK_DIVIDER);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIVIDER - 1);
    localparam logic signed [Q_WIDTH-1:0] PosInit = Q_WIDTH'(INIT_POSITION * 256);
    localparam logic signed [INT_WIDTH-1:0] PosOutInit = INT_WIDTH'(INIT_POSITION);

    state_e state_q, state_d;

    logic [CntW-1:0]               cnt_q;
    logic                          tick;
    logic signed [INT_WIDTH-1:0]   force_q;
    logic signed [ACC_WIDTH-1:0]   accel_q, accel_d;
    logic signed [Q_WIDTH-1:0]     pos_q, vel_q;
    logic                          vel_sat_q;
    logic signed [INT_WIDTH-1:0]   pos_out_q, vel_out_q;
    logic                          sat_q, overrun_q;

    logic signed [ACC_WIDTH-1:0]   force_ext, pos_ext;
    logic signed [Q_WIDTH-1:0]     dv, dp, vel_sum, pos_sum;
    logic                          vel_clamp, pos_clamp;

    assign tick = (cnt_q == CntMax);

    // State register.
    always_ff @(posedge clock) begin
        if (isReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one state per cycle once a tick starts an update.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (tick) state_d = StAccel;
            StAccel:    state_d = StVelocity;
            StVelocity: state_d = StPosition;
            StPosition: state_d = StPublish;
            StPublish:  state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Output logic.
    always_comb begin
        sampleValid = (state_q == StPublish);
        positionOut = pos_out_q;
        velocityOut = vel_out_q;
        saturated   = sat_q;
        overrun     = overrun_q;
    end

    // Acceleration: force minus spring restoring term (minus damping if enabled).
    always_comb begin
        force_ext = {{(ACC_WIDTH-INT_WIDTH){force_q[INT_WIDTH-1]}}, force_q};
        pos_ext   = {{(ACC_WIDTH-Q_WIDTH){pos_q[Q_WIDTH-1]}}, pos_q};
        accel_d   = (force_ext <<< FRAC_BITS) - (pos_ext >>> SPRING_SHIFT);
`ifdef PENDULUM_DAMPING_EN
        accel_d   = accel_d
                  - ({{(ACC_WIDTH-Q_WIDTH){vel_q[Q_WIDTH-1]}}, vel_q} >>> DAMP_SHIFT);
`endif
    end

`ifndef PENDULUM_DAMPING_EN
    logic unused_damp_shift;
    assign unused_damp_shift = (DAMP_SHIFT != 0);
`endif

    // |accel| stays below 2^16, so for DT_SHIFT >= 1 the scaled step fits 16 bits.
    assign dv = Q_WIDTH'(accel_q >>> DT_SHIFT);
    // vel_q already holds the velocity written in the VELOCITY cycle.
    assign dp = vel_q >>> DT_SHIFT;

    saturating_adder u_vel_add (
        .a_i     (vel_q),
        .b_i     (dv),
        .sum_o   (vel_sum),
        .clamp_o (vel_clamp)
    );

    saturating_adder u_pos_add (
        .a_i     (pos_q),
        .b_i     (dp),
        .sum_o   (pos_sum),
        .clamp_o (pos_clamp)
    );

    // Datapath and tick counter.
    always_ff @(posedge clock) begin
        if (isReset) begin
            cnt_q     <= '0;
            force_q   <= '0;
            accel_q   <= '0;
            pos_q     <= PosInit;
            vel_q     <= '0;
            vel_sat_q <= 1'b0;
            pos_out_q <= PosOutInit;
            vel_out_q <= '0;
            sat_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // Wrap on the count itself so the period never depends on the FSM.
            cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
            if (tick && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (tick) force_q <= forceIn;
                end
                StAccel: begin
                    accel_q <= accel_d;
                end
                StVelocity: begin
                    vel_q     <= vel_sum;
                    vel_sat_q <= vel_clamp;
                end
                StPosition: begin
                    // Output registers load here so they are new in the PUBLISH cycle.
                    pos_q     <= pos_sum;
                    pos_out_q <= pos_sum[Q_WIDTH-1:FRAC_BITS];
                    vel_out_q <= vel_q[Q_WIDTH-1:FRAC_BITS];
                    sat_q     <= vel_sat_q | pos_clamp;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pendulum_plant.sv
// Directed bench: one default plant (TICK_DIVIDER=1000) and one fast plant (6).
module tb_pendulum_plant;

    logic clk;
    logic rst_a, rst_b;
    logic signed [7:0] force_a, force_b;
    logic signed [7:0] pos_a, vel_a, pos_b, vel_b;
    logic sv_a, sat_a, ovr_a, sv_b, sat_b, ovr_b;

    int n_checks = 0;
    int n_fail   = 0;

    pendulum_plant dut_a (
        .clock       (clk),
        .isReset     (rst_a),
        .forceIn     (force_a),
        .positionOut (pos_a),
        .velocityOut (vel_a),
        .sampleValid (sv_a),
        .saturated   (sat_a),
        .overrun     (ovr_a)
    );

    pendulum_plant #(.TICK_DIVIDER(6)) dut_b (
        .clock       (clk),
        .isReset     (rst_b),
        .forceIn     (force_b),
        .positionOut (pos_b),
        .velocityOut (vel_b),
        .sampleValid (sv_b),
        .saturated   (sat_b),
        .overrun     (ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Steps at least once until the selected sampleValid is high; n = -1 on timeout.
    task automatic wait_valid(input bit sel_b, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(sel_b ? sv_b : sv_a) && n < limit);
        if (!(sel_b ? sv_b : sv_a)) n = -1;
    endtask

    // Reference plant step on plain integers.
    function automatic void plant_step(input int f, inout int p, inout int v, output int sat);
        int acc, nv, np;
        sat = 0;
        acc = f * 256 - (p >>> 3);
`ifdef PENDULUM_DAMPING_EN
        acc = acc - (v >>> 4);
`endif
        nv = v + (acc >>> 2);
        if (nv > 32767) begin nv = 32767; sat = 1; end
        if (nv < -32768) begin nv = -32768; sat = 1; end
        np = p + (nv >>> 2);
        if (np > 32767) begin np = 32767; sat = 1; end
        if (np < -32768) begin np = -32768; sat = 1; end
        p = np;
        v = nv;
    endfunction

    initial begin
        int n, m_pos, m_vel, m_sat, prev, reached, extra;
        rst_a = 1'b1;
        rst_b = 1'b1;
        force_a = 8'sd0;
        force_b = 8'sd0;
        repeat (3) step();

        // Reset values.
        chk("rst_pos", pos_a, 30);
        chk("rst_vel", vel_a, 0);
        chk("rst_valid", sv_a, 0);
        chk("rst_sat", sat_a, 0);
        chk("rst_overrun", ovr_a, 0);

        // Default divider: tick at count 999, sample four cycles later.
        rst_a = 1'b0;
        wait_valid(1'b0, 1100, n);
        chk("a_first_latency", n, 1003);
        chk("a_first_pos", pos_a, 29);
        chk("a_first_vel", vel_a, -1);
        chk("a_first_sat", sat_a, 0);
        step();
        chk("a_valid_pulse", sv_a, 0);
        rst_a = 1'b1;

        // Force changed the cycle after the tick (tick at cycle 5).
        rst_b = 1'b0;
        repeat (6) step();
        force_b = 8'sd100;
        repeat (3) step();
        chk("b_late_force_valid", sv_b, 1);
        chk("b_late_force_pos", pos_b, 29);
        chk("b_late_force_vel", vel_b, -1);
        repeat (6) step();
        chk("b_force100_valid", sv_b, 1);
        chk("b_force100_pos", pos_b, 35);
        chk("b_force100_vel", vel_b, 23);
        wait_valid(1'b1, 20, n);
        chk("b_period", n, 6);
        chk("b_no_overrun", ovr_b, 0);

        // Inject a tick during POSITION (sample at S, POSITION at S+5).
        repeat (5) step();
        force dut_b.tick = 1'b1;
        step();
        release dut_b.tick;
        chk("b_overrun_set", ovr_b, 1);
        repeat (12) step();
        chk("b_overrun_sticky", ovr_b, 1);
        force_b = 8'sd0;
        rst_b = 1'b1;
        step();
        chk("b_overrun_cleared", ovr_b, 0);

        // Reset during VELOCITY.
        rst_b = 1'b0;
        wait_valid(1'b1, 20, n);
        chk("b_first_latency", n, 9);
        repeat (4) step();
        rst_b = 1'b1;
        step();
        chk("b_midreset_valid", sv_b, 0);
        chk("b_midreset_pos", pos_b, 30);
        chk("b_midreset_vel", vel_b, 0);
        rst_b = 1'b0;
        wait_valid(1'b1, 20, n);
        // Edges counted from the edge that sampled isReset high.
        chk("b_midreset_latency", n + 1, 10);
        chk("b_midreset_pos2", pos_b, 29);

        // Full force: monotonic climb into saturation, no wrap.
        rst_b = 1'b1;
        force_b = 8'sd127;
        step();
        rst_b = 1'b0;
        m_pos = 30 * 256;
        m_vel = 0;
        prev = 30;
        reached = 0;
        extra = 0;
        for (int u = 0; u < 40 && extra < 3; u++) begin
            wait_valid(1'b1, 20, n);
            chk("b127_sample_seen", int'(n > 0), 1);
            plant_step(127, m_pos, m_vel, m_sat);
            chk("b127_pos", pos_b, m_pos >>> 8);
            chk("b127_vel", vel_b, m_vel >>> 8);
            chk("b127_sat", sat_b, m_sat);
            chk("b127_monotonic", int'(pos_b >= prev), 1);
            prev = pos_b;
            if (reached != 0) extra++;
            if (pos_b == 8'sd127) begin
                reached = 1;
                chk("b127_sat_when_clamped", sat_b, 1);
            end
        end
        chk("b127_reached_max", reached, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
